// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the IO data-bus path: 8-entry byte FIFO,
// programmable bit divisor, one-cycle registered reads and a FIFO-drained interrupt.
module io_uart_tx #(
    parameter int          ADDR_W          = 14,
    parameter int          FIFO_DEPTH_LOG2 = 3,
    parameter logic [15:0] DIV_RESET       = 16'd434
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              IO_REQ,
    input  logic              IO_WE,
    input  logic              IO_RE,
    input  logic              DBE,
    input  logic [ADDR_W-1:0] IO_ADDR,
    input  logic [31:0]       IO_WD,
    output logic [31:0]       IO_RD,
    output logic              TXD,
    output logic              IRQ
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]              CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]              CNT_FULL = CW'(DEPTH);
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE  = {{(FIFO_DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t                     state_r, state_nx_s;
    logic [7:0]                 fifo_mem_r [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]              count_r;
    logic [15:0]                divisor_r, div_eff_s, div_q_r, div_q_nx_s;
    logic [15:0]                timer_r, timer_nx_s;
    logic [7:0]                 shift_r, shift_nx_s;
    logic [2:0]                 bit_idx_r, bit_idx_nx_s;
    logic                       irq_en_r, overrun_r, txd_r, txd_nx_s;
    logic [31:0]                io_rd_r, rd_data_s, status_s;
    logic                       wr_en_s, rd_en_s, push_req_s, push_ok_s, pop_s;
    logic                       full_s, empty_s, busy_s, bit_end_s;
    logic                       unused_ok_s;

    assign wr_en_s    = IO_REQ & IO_WE & ~DBE;
    assign rd_en_s    = IO_REQ & IO_RE & ~DBE;
    assign push_req_s = wr_en_s & (IO_ADDR[1:0] == 2'd0);
    assign full_s     = (count_r == CNT_FULL);
    assign empty_s    = (count_r == {CW{1'b0}});
    assign busy_s     = (state_r != ST_IDLE);
    assign bit_end_s  = (timer_r == 16'd0);
    assign div_eff_s  = (divisor_r == 16'd0) ? 16'd1 : divisor_r;
    // A push into a full FIFO is still accepted when a pop frees the slot on the same edge.
    assign push_ok_s  = push_req_s & (~full_s | pop_s);
    assign unused_ok_s = ^{IO_ADDR[ADDR_W-1:2], IO_WD[31:16]};

    assign IO_RD = io_rd_r;
    assign TXD   = txd_r;
    assign IRQ   = irq_en_r & empty_s & ~busy_s;

    // Transmit FSM and bit-timing datapath registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r   <= ST_IDLE;
            timer_r   <= 16'd0;
            div_q_r   <= 16'd1;
            shift_r   <= 8'd0;
            bit_idx_r <= 3'd0;
            txd_r     <= 1'b1;
        end else begin
            state_r   <= state_nx_s;
            timer_r   <= timer_nx_s;
            div_q_r   <= div_q_nx_s;
            shift_r   <= shift_nx_s;
            bit_idx_r <= bit_idx_nx_s;
            txd_r     <= txd_nx_s;
        end
    end

    // Next state, pop decision and next bit-timer/shift values.
    always_comb begin
        state_nx_s   = state_r;
        pop_s        = 1'b0;
        timer_nx_s   = timer_r;
        div_q_nx_s   = div_q_r;
        shift_nx_s   = shift_r;
        bit_idx_nx_s = bit_idx_r;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    state_nx_s = ST_START;
                    pop_s      = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) state_nx_s = ST_DATA;
                else           state_nx_s = ST_START;
            end
            ST_DATA: begin
                if (bit_end_s && (bit_idx_r == 3'd7)) state_nx_s = ST_STOP;
                else                                  state_nx_s = ST_DATA;
            end
            ST_STOP: begin
                if (bit_end_s && !empty_s) begin
                    state_nx_s = ST_START;
                    pop_s      = 1'b1;
                end else if (bit_end_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_STOP;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
        // A new frame latches the divisor, so DIVISOR writes never disturb a frame in flight.
        if (pop_s) begin
            shift_nx_s   = fifo_mem_r[rd_ptr_r];
            div_q_nx_s   = div_eff_s;
            timer_nx_s   = div_eff_s - 16'd1;
            bit_idx_nx_s = 3'd0;
        end else if (busy_s && bit_end_s) begin
            timer_nx_s = div_q_r - 16'd1;
            if (state_r == ST_DATA) begin
                shift_nx_s   = {1'b0, shift_r[7:1]};
                bit_idx_nx_s = bit_idx_r + 3'd1;
            end else begin
                shift_nx_s   = shift_r;
                bit_idx_nx_s = bit_idx_r;
            end
        end else if (busy_s) begin
            timer_nx_s = timer_r - 16'd1;
        end else begin
            timer_nx_s = timer_r;
        end
    end

    // Serial line level for the state being entered.
    always_comb begin
        txd_nx_s = 1'b1;
        case (state_nx_s)
            ST_START: txd_nx_s = 1'b0;
            ST_DATA:  txd_nx_s = shift_nx_s[0];
            default:  txd_nx_s = 1'b1;
        endcase
    end

    // FIFO storage; stale contents are harmless since pointers gate them.
    always_ff @(posedge CLK) begin
        if (push_ok_s) begin
            fifo_mem_r[wr_ptr_r] <= IO_WD[7:0];
        end else begin
            fifo_mem_r[wr_ptr_r] <= fifo_mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_r <= {FIFO_DEPTH_LOG2{1'b0}};
            rd_ptr_r <= {FIFO_DEPTH_LOG2{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)     rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Read mux: status assembled from pre-edge state.
    always_comb begin
        status_s             = 32'd0;
        status_s[0]          = full_s;
        status_s[1]          = empty_s;
        status_s[2]          = busy_s;
        status_s[3]          = overrun_r;
        status_s[4 +: CW]    = count_r;
        case (IO_ADDR[1:0])
            2'd0:    rd_data_s = 32'd0;
            2'd1:    rd_data_s = status_s;
            2'd2:    rd_data_s = {16'd0, divisor_r};
            2'd3:    rd_data_s = {31'd0, irq_en_r};
            default: rd_data_s = 32'd0;
        endcase
    end

    // Bus-visible registers, read data and sticky overrun.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            divisor_r <= DIV_RESET;
            irq_en_r  <= 1'b0;
            overrun_r <= 1'b0;
            io_rd_r   <= 32'd0;
        end else begin
            if (wr_en_s && (IO_ADDR[1:0] == 2'd2)) divisor_r <= IO_WD[15:0];
            if (wr_en_s && (IO_ADDR[1:0] == 2'd3)) irq_en_r  <= IO_WD[0];
            if (rd_en_s) io_rd_r <= rd_data_s;
            // A dropped push wins over a simultaneous clear-on-read so the loss is never hidden.
            if (push_req_s && !push_ok_s) begin
                overrun_r <= 1'b1;
            end else if (rd_en_s && (IO_ADDR[1:0] == 2'd1)) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed testbench for io_uart_tx: register access, frame shape, FIFO overrun,
// interrupt timing, bus-error qualification, divisor latching and async reset.
module tb_io_uart_tx;

    logic        CLK;
    logic        RESET;
    logic        IO_REQ, IO_WE, IO_RE, DBE;
    logic [13:0] IO_ADDR;
    logic [31:0] IO_WD;
    logic [31:0] IO_RD;
    logic        TXD, IRQ;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int k;
    logic txd_hist [0:1023];
    logic irq_hist [0:1023];
    logic [7:0] burst [0:8];

    io_uart_tx dut (
        .CLK(CLK), .RESET(RESET), .IO_REQ(IO_REQ), .IO_WE(IO_WE), .IO_RE(IO_RE),
        .DBE(DBE), .IO_ADDR(IO_ADDR), .IO_WD(IO_WD), .IO_RD(IO_RD), .TXD(TXD), .IRQ(IRQ)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Per-cycle record of the line and interrupt, indexed by edges seen so far.
    always @(negedge CLK) begin
        if (cyc < 1024) begin
            txd_hist[cyc] <= TXD;
            irq_hist[cyc] <= IRQ;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic bus(input logic we, input logic re, input logic dbe,
                       input logic [1:0] a, input logic [31:0] wd);
        IO_REQ  = 1'b1;
        IO_WE   = we;
        IO_RE   = re;
        DBE     = dbe;
        IO_ADDR = {12'd0, a};
        IO_WD   = wd;
        @(negedge CLK);
        IO_REQ  = 1'b0;
        IO_WE   = 1'b0;
        IO_RE   = 1'b0;
        DBE     = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus(1'b1, 1'b0, 1'b0, a, d);
    endtask

    task automatic rd(input logic [1:0] a);
        bus(1'b0, 1'b1, 1'b0, a, 32'd0);
    endtask

    function automatic logic [63:0] get_obs(input int base, input int len);
        logic [63:0] v = 64'd0;
        for (int i = 0; i < len; i++) v[i] = txd_hist[base + i];
        return v;
    endfunction

    // Expected line levels, one per cycle, for a start/8 data/stop frame at d clocks per bit.
    function automatic logic [63:0] exp_frame(input logic [7:0] b, input int d);
        logic [63:0] v = 64'd0;
        logic [9:0]  fr = {1'b1, b, 1'b0};
        for (int i = 0; i < 10 * d; i++) v[i] = fr[i / d];
        return v;
    endfunction

    initial begin
        burst[0] = 8'h01; burst[1] = 8'h80; burst[2] = 8'hFF;
        burst[3] = 8'h00; burst[4] = 8'h5A; burst[5] = 8'hC3;
        burst[6] = 8'h7E; burst[7] = 8'h96; burst[8] = 8'h3C;
        RESET = 1'b0; IO_REQ = 1'b0; IO_WE = 1'b0; IO_RE = 1'b0; DBE = 1'b0;
        IO_ADDR = 14'd0; IO_WD = 32'd0;
        repeat (3) @(negedge CLK);
        chk("reset_txd", 64'(TXD), 64'd1);
        chk("reset_irq", 64'(IRQ), 64'd0);
        chk("reset_rd", 64'(IO_RD), 64'd0);
        RESET = 1'b1;
        rd(2'd1);
        chk("reset_status", 64'(IO_RD), 64'h2);
        rd(2'd2);
        chk("reset_divisor", 64'(IO_RD), 64'h1B2);

        // Single frame at 4 clocks per bit
        wr(2'd2, 32'd4);
        rd(2'd2);
        chk("div4_readback", 64'(IO_RD), 64'd4);
        wr(2'd0, 32'hA5);
        k = cyc;
        chk("a5_txd_after_write", 64'(TXD), 64'd1);
        repeat (42) @(negedge CLK);
        chk("a5_frame", get_obs(k + 1, 40), exp_frame(8'hA5, 4));
        chk("a5_idle_after", 64'(txd_hist[k + 41]), 64'd1);
        rd(2'd1);
        chk("a5_status_idle", 64'(IO_RD), 64'h2);

        // Back-to-back burst at 1 clock per bit with overrun
        wr(2'd2, 32'd1);
        for (int j = 0; j < 9; j++) begin
            wr(2'd0, {24'd0, burst[j]});
            if (j == 0) k = cyc;
        end
        rd(2'd1);
        chk("burst_status_full", 64'(IO_RD), 64'h85);
        wr(2'd0, 32'hEE);
        rd(2'd1);
        chk("burst_status_overrun", 64'(IO_RD), 64'h8D);
        rd(2'd1);
        chk("burst_overrun_cleared", 64'(IO_RD), 64'h74);
        repeat (85) @(negedge CLK);
        for (int j = 0; j < 9; j++) begin
            chk($sformatf("burst_frame%0d", j), get_obs(k + 1 + 10 * j, 10), exp_frame(burst[j], 1));
        end
        chk("burst_idle_after", 64'(txd_hist[k + 91]), 64'd1);
        rd(2'd1);
        chk("burst_status_drained", 64'(IO_RD), 64'h2);

        // Interrupt drop and return around one frame at 2 clocks per bit
        wr(2'd3, 32'd1);
        wr(2'd2, 32'd2);
        chk("irq_idle_enabled", 64'(IRQ), 64'd1);
        wr(2'd0, 32'h3C);
        k = cyc;
        chk("irq_low_after_push", 64'(IRQ), 64'd0);
        repeat (22) @(negedge CLK);
        chk("irq_low_last_stop", 64'(irq_hist[k + 20]), 64'd0);
        chk("irq_reassert", 64'(irq_hist[k + 21]), 64'd1);
        chk("irq_frame", get_obs(k + 1, 20), exp_frame(8'h3C, 2));

        // Bus error suppresses push and read-data load
        rd(2'd3);
        chk("ctrl_readback", 64'(IO_RD), 64'd1);
        bus(1'b1, 1'b0, 1'b1, 2'd0, 32'h55);
        repeat (3) @(negedge CLK);
        chk("dbe_txd_idle", 64'(TXD), 64'd1);
        chk("dbe_irq_still_empty", 64'(IRQ), 64'd1);
        bus(1'b0, 1'b1, 1'b1, 2'd1, 32'd0);
        chk("dbe_rd_held", 64'(IO_RD), 64'd1);
        rd(2'd1);
        chk("dbe_status_empty", 64'(IO_RD), 64'h2);

        // Divisor change mid-frame applies to the following frame only
        wr(2'd2, 32'd3);
        wr(2'd0, 32'hC5);
        k = cyc;
        wr(2'd0, 32'h2B);
        wr(2'd2, 32'd5);
        repeat (85) @(negedge CLK);
        chk("div3_frame", get_obs(k + 1, 30), exp_frame(8'hC5, 3));
        chk("div5_frame", get_obs(k + 31, 50), exp_frame(8'h2B, 5));
        chk("div_idle_after", 64'(txd_hist[k + 81]), 64'd1);

        // Asynchronous reset in the middle of a start bit
        wr(2'd0, 32'h0F);
        @(negedge CLK);
        chk("rst_txd_start_low", 64'(TXD), 64'd0);
        #2 RESET = 1'b0;
        #1;
        chk("rst_txd_async_high", 64'(TXD), 64'd1);
        chk("rst_irq_low", 64'(IRQ), 64'd0);
        @(negedge CLK);
        RESET = 1'b1;
        rd(2'd1);
        chk("rst_status_empty", 64'(IO_RD), 64'h2);
        rd(2'd2);
        chk("rst_divisor_default", 64'(IO_RD), 64'h1B2);
        repeat (3) @(negedge CLK);
        chk("rst_txd_stays_high", 64'(TXD), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/io_uart_tx.md
# io_uart_tx

Memory-mapped UART transmitter on the IO side of the data bus: it decodes the same IO request strobes that `phy_mem` steers away from on-chip RAM, buffers CPU-written bytes in an 8-entry FIFO, and serialises them as 8N1 frames on `TXD`. Register reads return data with one cycle of latency, matching RAM timing, so the memory-side `io_request_q` mux can select `IO_RD` without extra wait states. It also raises a level interrupt when the FIFO has drained.

## Interface
- `ADDR_W`, default 14: width of `IO_ADDR` (word address; equal to `RAM_DEPTH`).
- `FIFO_DEPTH_LOG2`, default 3: FIFO holds 2^N bytes (8).
- `DIV_RESET`, default 16'd434: reset value of DIVISOR, in clocks per bit.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `IO_REQ` in 1: access targets IO space this cycle.
- `IO_WE` in 1: write strobe.
- `IO_RE` in 1: read strobe.
- `DBE` in 1: data bus error this cycle; suppresses all register side effects.
- `IO_ADDR` in ADDR_W: word address; only `IO_ADDR[1:0]` is decoded.
- `IO_WD` in 32: write data.
- `IO_RD` out 32: registered read data, valid the cycle after the read.
- `TXD` out 1: serial output, idles high.
- `IRQ` out 1: `CTRL.irq_en & fifo_empty & ~busy`.

## Operation
Register map, selected by `IO_ADDR[1:0]`:
- 0 TXDATA, write-only: pushes `IO_WD[7:0]`. Reads return 0.
- 1 STATUS, read-only:
  - bit0 full, bit1 empty, bit2 busy, bit3 overrun (sticky), bits[7:4] count (0..8).
  - Other bits read 0.
  - A read clears overrun.
- 2 DIVISOR, R/W, bits[15:0]: clocks per bit. A value of 0 is treated as 1.
- 3 CTRL, R/W: bit0 irq_en. Resets to 0.

Access qualification:
- Write effect occurs when `IO_REQ & IO_WE & ~DBE`.
- Read effect occurs when `IO_REQ & IO_RE & ~DBE`. Its side effects are the clear-on-read of overrun and the load of `IO_RD`.
- When `IO_REQ` is low, `IO_RD` holds its previous value.

FIFO:
- Circular buffer with read and write pointers that wrap modulo 2^N, plus a (N+1)-bit count.
- A push while full is dropped and sets overrun.
- Push and pop on the same edge while full: the push is accepted and count is unchanged.
- Push and pop on the same edge while empty: not possible, because pop requires a non-empty FIFO before the edge.

Transmit FSM, with states IDLE, START, DATA, STOP:
- IDLE:
  - Stay while the FIFO is empty.
  - If non-empty: pop into the shift register, latch the effective divisor into `div_q`, and go to START.
- START: `TXD`=0 for `div_q` cycles, then DATA with bit index 0.
- DATA:
  - `TXD`=shift[0] (LSB first) for `div_q` cycles, then shift right.
  - After bit index 7, go to STOP.
- STOP: `TXD`=1 for `div_q` cycles. At the end, pop and go directly to START if the FIFO is non-empty, else go to IDLE.
- busy = (state != IDLE).
- A DIVISOR write takes effect only at the next frame start; an in-flight frame is not disturbed.
- Bit timer: a 16-bit down-counter loaded with `div_q-1` at each bit start. The bit ends when the counter reaches 0.

## Timing
- Reset values: `TXD`=1, `IO_RD`=0, `IRQ`=0. Also state=IDLE, FIFO empty, overrun=0, DIVISOR=`DIV_RESET`, CTRL=0.
- Reset asserted mid-frame: `TXD` goes to 1 asynchronously and FIFO contents are discarded.
- Read latency: the read strobe is sampled at edge N and `IO_RD` is valid after edge N. STATUS reflects state before edge N.
- Push at edge N into an empty FIFO with the FSM idle:
  - Count becomes 1 after edge N.
  - Pop and START occur at edge N+1, so `TXD` falls after edge N+1.
- Frame length is exactly 10·`div_q` cycles. Back-to-back frames have no idle gap.
- `IRQ` is combinational from registered state. It asserts in the cycle after the edge that completes the last STOP bit with the FIFO empty.

## Test plan
- Reset then STATUS read: `IO_RD`=0x0000_0002 (empty), `TXD`=1, `IRQ`=0.
- DIVISOR=4, write 0xA5 to TXDATA. Required: `TXD` low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles. Total 40 cycles, starting 1 cycle after the write edge.
- DIVISOR=1, write 9 bytes back-to-back:
  - STATUS shows full after the 9th write (one byte already popped), count=8, overrun=0.
  - A 10th write sets overrun=1; the next STATUS read shows bit3 set and clears it.
  - All 9 frames are emitted contiguously, 90 cycles.
- CTRL=1, write one byte with DIVISOR=2: `IRQ` deasserts while busy and reasserts exactly 20 cycles after the START edge.
- Write TXDATA with `DBE`=1: no push, count stays 0, `TXD` stays 1. A STATUS read with `DBE`=1 leaves `IO_RD` unchanged.
- DIVISOR=3, start a frame, write DIVISOR=5 mid-frame: the current frame keeps 3-cycle bits and the next frame uses 5. Asserting `RESET` mid-frame forces `TXD`=1 immediately, with empty=1 after release.
